load_store_unit: RTL

Parametrised memory-stage load/store unit between execute and writeback. It accepts one load or store per handshake and computes the effective address. It drives a single-port data memory through a request/response handshake that tolerates variable latency, and steers byte lanes for both directions. Loaded data is returned sign- or zero-extended, with an optional misaligned-access fault.

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with byte-lane steering
//
// Accepts one load or store per handshake and computes the effective
// address. It issues a single request to a variable-latency data memory,
// then returns the sign- or zero-extended load result. Every output is a
// register.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : a misaligned access issues no memory request and completes
//               with out_fault=1
//   undefined : the lane offset is rounded down to the access size and
//               out_fault stays 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operation handshake from execute
//   in_is_store, in_funct3   operation kind and RISC-V width/sign field
//   in_base, in_offset       rs1 value and signed 12-bit immediate
//   in_store_data, in_tag    rs2 value (LSB-aligned) and opaque sideband
//   mem_req_valid/ready      memory request handshake
//   mem_we, mem_addr         write flag, word-aligned byte address
//   mem_wdata, mem_byte_enable  lane-shifted write data and lane enables
//   mem_rsp_valid, mem_rdata read response (loads only)
//   out_valid/out_ready      result handshake to writeback
//   out_load_data, out_tag   extended load data (0 for stores), captured tag
//   out_fault                misaligned-access fault
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_is_store,
    input  logic [2:0]                in_funct3,
    input  logic [DATA_WIDTH-1:0]     in_base,
    input  logic [11:0]               in_offset,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_enable,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_load_data,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      out_fault
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam logic [1:0] MAX_LOG = 2'(OFS);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
    state_t state;

    // Access attributes kept for the response path
    logic [OFS-1:0] ofs_q;
    logic [1:0]     size_q;
    logic           uns_q;

    // Request-side decode of the incoming operation
    logic [DATA_WIDTH-1:0] ea_full;
    logic [ADDR_WIDTH-1:0] ea;
    logic [OFS-1:0]        raw_ofs;
    logic [OFS-1:0]        size_mask;
    logic [OFS-1:0]        ofs;
    logic [1:0]            size_log;
    logic                  is_unsigned;
    logic [3:0]            size_bytes;
    logic [BYTES-1:0]      be_base;
    logic [BYTES-1:0]      be;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  misaligned;
`endif

    always_comb begin
        ea_full = in_base + {{(DATA_WIDTH-12){in_offset[11]}}, in_offset};
        ea      = ADDR_WIDTH'(ea_full);
        raw_ofs = ea[OFS-1:0];
        // Widths wider than the word, and the reserved encoding, fall back
        // to a full-word unsigned access.
        if (in_funct3 == 3'b111 || in_funct3[1:0] > MAX_LOG) begin
            size_log    = MAX_LOG;
            is_unsigned = 1'b1;
        end else begin
            size_log    = in_funct3[1:0];
            is_unsigned = in_funct3[2];
        end
        size_bytes = 4'd1 << size_log;
        size_mask  = OFS'(size_bytes - 4'd1);
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = |(raw_ofs & size_mask);
        ofs        = raw_ofs;
`else
        ofs        = raw_ofs & ~size_mask;
`endif
        be_base = BYTES'((16'd1 << size_bytes) - 16'd1);
        be      = be_base << ofs;
    end

    // Response-side lane extraction and extension
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] lmask;
    logic                  sgn;
    logic [DATA_WIDTH-1:0] ext;

    always_comb begin
        shifted = mem_rdata >> {ofs_q, 3'b000};
        case (size_q)
            2'd0:    begin lmask = DATA_WIDTH'(8'hFF);         sgn = shifted[7];  end
            2'd1:    begin lmask = DATA_WIDTH'(16'hFFFF);      sgn = shifted[15]; end
            2'd2:    begin lmask = DATA_WIDTH'(32'hFFFF_FFFF); sgn = shifted[31]; end
            default: begin lmask = '1;                         sgn = shifted[DATA_WIDTH-1]; end
        endcase
        ext = (shifted & lmask) | ((sgn && !uns_q) ? ~lmask : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            in_ready        <= 1'b1;
            mem_req_valid   <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            out_valid       <= 1'b0;
            out_load_data   <= '0;
            out_tag         <= '0;
            out_fault       <= 1'b0;
            ofs_q           <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready        <= 1'b0;
                        ofs_q           <= ofs;
                        size_q          <= size_log;
                        uns_q           <= is_unsigned;
                        out_tag         <= in_tag;
                        out_load_data   <= '0;
                        out_fault       <= 1'b0;
                        mem_we          <= in_is_store;
                        mem_addr        <= {ea[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                        mem_wdata       <= in_store_data << {ofs, 3'b000};
                        mem_byte_enable <= be;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_fault <= 1'b1;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                        end
`else
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_we) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        out_load_data <= ext;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
